remote_cmd_sender: RTL and testbench
====================================

// Module: remote_cmd_sender
// PURPOSE
//  Initiator end of the 2-byte command link: serialises a 16-bit command as two
//  UART bytes (high byte first, then low byte) through the team UART block, then
//  waits for the single 8-bit response byte. Sits in the host/remote side and talks
//  to UART_wrapper on the DUT side. Response wait is bounded by a timeout counter.
// PARAMETERS
//  TIMEOUT_CYC  24'd5_000_000  clk cycles allowed between cmd_snt and response byte
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous, active-low reset
//  snd_cmd      in   1   request pulse; cmd sampled on the cycle it is accepted
//  cmd          in   16  command to send; [15:8] goes first
//  clr_resp_rdy in   1   consumer acknowledge, clears resp_rdy
//  RX           in   1   serial in from responder
//  TX           out  1   serial out to responder
//  busy         out  1   high in every state except IDLE
//  cmd_snt      out  1   set when low byte finishes, cleared on next accepted snd_cmd
//  resp_rdy     out  1   response byte valid
//  resp         out  8   last response byte received
//  timeout      out  1   one-cycle pulse when response wait expires
// BEHAVIOUR
//  Reset: state IDLE; busy=0, cmd_snt=0, resp_rdy=0, resp=8'h00, timeout=0, TX=1.
//  Internal: 16-bit cmd_hold; tx_data = sel_hi ? cmd_hold[15:8] : cmd_hold[7:0];
//   24-bit wait counter. UART instance: trmt starts a byte, tx_done clears on trmt.
//  States: IDLE, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, WAIT_RESP.
//  IDLE: snd_cmd=1 -> cmd_hold<=cmd, cmd_snt<=0, resp_rdy<=0 -> SEND_HI.
//   rx_rdy in IDLE: clr_rx_rdy pulsed, byte discarded, resp unchanged.
//  SEND_HI: trmt=1 exactly one cycle, sel_hi=1 -> WAIT_HI.
//  WAIT_HI: on tx_done=1 -> SEND_LO (no back-to-back gap longer than 1 cycle).
//  SEND_LO: trmt=1 one cycle, sel_hi=0 -> WAIT_LO.
//  WAIT_LO: on tx_done=1 -> cmd_snt<=1, counter<=0 -> WAIT_RESP.
//  WAIT_RESP: counter increments each cycle.
//   rx_rdy=1 -> resp<=rx_data, resp_rdy<=1, clr_rx_rdy=1 -> IDLE.
//   counter==TIMEOUT_CYC-1 and no rx_rdy -> timeout=1 one cycle -> IDLE, resp kept.
//   rx_rdy and expiry same cycle: response wins, no timeout pulse.
//  snd_cmd outside IDLE ignored; cmd changes after acceptance have no effect.
//  Bytes arriving during SEND_*/WAIT_HI/WAIT_LO: left in UART (rx_rdy held), consumed
//   as the response on entry to WAIT_RESP.
//  clr_resp_rdy clears resp_rdy; simultaneous set (rx_rdy in WAIT_RESP) wins.
//  Latency snd_cmd -> first TX start bit: 2 clks. Total = 2 byte frames + ~4 clks.
//  rst_n mid-transfer: immediate return to reset values, TX forced idle-high by UART.
// TESTING
//  1 Loopback to a UART_wrapper: cmd=16'hA55A, snd_cmd -> DUT side cmd=16'hA55A,
//    cmd_rdy=1; byte order on TX 8'hA5 then 8'h5A.
//  2 Responder returns 8'hA5 after cmd_snt -> resp=8'hA5, resp_rdy=1, busy=0,
//    timeout never asserted; clr_resp_rdy -> resp_rdy=0 next clk.
//  3 TIMEOUT_CYC=1000, no response -> timeout pulse exactly 1000 clks after cmd_snt,
//    state IDLE, resp_rdy=0, resp unchanged.
//  4 snd_cmd re-pulsed with cmd=16'h1234 while sending 16'hBEEF -> only 16'hBEEF
//    transmitted; 16'h1234 never appears on TX.
//  5 rst_n low during WAIT_LO -> TX=1, busy=0, cmd_snt=0 within same cycle; next
//    snd_cmd 16'h0F0F sent cleanly with correct framing.
//  6 Stray byte 8'h33 on RX while IDLE -> discarded; next command's response 8'hCC
//    reported as resp=8'hCC, not 8'h33.

Source files
------------

// File: rtl/remote_cmd_sender.sv
// Initiator end of the 2-byte command link: sends cmd high byte then low byte over
// an embedded 8N1 UART, then waits (bounded by TIMEOUT_CYC) for one response byte.
module remote_cmd_sender #(
  parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000,
  parameter int          BAUD_DIV    = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd_cmd,
  input  logic [15:0] cmd,
  input  logic        clr_resp_rdy,
  input  logic        RX,
  output logic        TX,
  output logic        busy,
  output logic        cmd_snt,
  output logic        resp_rdy,
  output logic [7:0]  resp,
  output logic        timeout,
  output logic [2:0]  dbg_state
);

  // Handshake: snd_cmd is a request qualified only in IDLE; busy is its inverse ready.
  typedef enum logic [2:0] {
    IDLE, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, WAIT_RESP
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] BAUD_HALF = 16'(BAUD_DIV / 2 - 1);
  localparam logic [23:0] WAIT_LAST = TIMEOUT_CYC - 24'd1;

  state_t      state;
  logic [15:0] cmd_hold;
  logic [23:0] wait_cnt;

  logic        trmt, sel_hi, clr_rx_rdy;
  logic [7:0]  tx_data;

  logic        tx_busy, tx_done;
  logic [8:0]  tx_shift;
  logic [3:0]  tx_bits;
  logic [15:0] tx_baud;

  logic        rx_sync1, rx_sync2, rx_busy, rx_rdy;
  logic [3:0]  rx_bits;
  logic [15:0] rx_baud;
  logic [7:0]  rx_shift, rx_data;

  assign trmt       = (state == SEND_HI) || (state == SEND_LO);
  assign sel_hi     = (state == SEND_HI);
  assign tx_data    = sel_hi ? cmd_hold[15:8] : cmd_hold[7:0];
  assign clr_rx_rdy = rx_rdy && ((state == IDLE) || (state == WAIT_RESP));
  assign busy       = (state != IDLE);
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cmd_hold <= 16'h0000;
      wait_cnt <= 24'd0;
      cmd_snt  <= 1'b0;
      resp_rdy <= 1'b0;
      resp     <= 8'h00;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (clr_resp_rdy) resp_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (snd_cmd) begin
            cmd_hold <= cmd;
            cmd_snt  <= 1'b0;
            resp_rdy <= 1'b0;
            state    <= SEND_HI;
          end
        end
        SEND_HI: state <= WAIT_HI;
        WAIT_HI: if (tx_done) state <= SEND_LO;
        SEND_LO: state <= WAIT_LO;
        WAIT_LO: begin
          if (tx_done) begin
            cmd_snt  <= 1'b1;
            wait_cnt <= 24'd0;
            state    <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          // A byte already waiting in the receiver beats an expiring counter.
          if (rx_rdy) begin
            resp     <= rx_data;
            resp_rdy <= 1'b1;
            state    <= IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 24'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Transmitter: start bit, 8 data bits LSB first, stop bit; tx_done stays set until next trmt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      TX       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      tx_shift <= 9'h1FF;
      tx_bits  <= 4'd0;
      tx_baud  <= 16'd0;
    end else if (trmt) begin
      TX       <= 1'b0;
      tx_shift <= {1'b1, tx_data};
      tx_bits  <= 4'd0;
      tx_baud  <= 16'd0;
      tx_busy  <= 1'b1;
      tx_done  <= 1'b0;
    end else if (tx_busy) begin
      if (tx_baud == BAUD_LAST) begin
        tx_baud <= 16'd0;
        if (tx_bits == 4'd9) begin
          tx_busy <= 1'b0;
          tx_done <= 1'b1;
        end else begin
          TX       <= tx_shift[0];
          tx_shift <= {1'b1, tx_shift[8:1]};
          tx_bits  <= tx_bits + 4'd1;
        end
      end else begin
        tx_baud <= tx_baud + 16'd1;
      end
    end
  end

  // Receiver: the start bit is re-checked at its midpoint, later bits sampled a full period apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync1 <= 1'b1;
      rx_sync2 <= 1'b1;
      rx_busy  <= 1'b0;
      rx_bits  <= 4'd0;
      rx_baud  <= 16'd0;
      rx_shift <= 8'h00;
      rx_data  <= 8'h00;
      rx_rdy   <= 1'b0;
    end else begin
      rx_sync1 <= RX;
      rx_sync2 <= rx_sync1;
      if (clr_rx_rdy) rx_rdy <= 1'b0;
      if (!rx_busy) begin
        if (!rx_sync2) begin
          rx_busy <= 1'b1;
          rx_baud <= 16'd0;
          rx_bits <= 4'd0;
        end
      end else if (rx_baud == ((rx_bits == 4'd0) ? BAUD_HALF : BAUD_LAST)) begin
        rx_baud <= 16'd0;
        if (rx_bits == 4'd0) begin
          if (rx_sync2) rx_busy <= 1'b0;
          else          rx_bits <= 4'd1;
        end else if (rx_bits == 4'd9) begin
          rx_busy <= 1'b0;
          if (rx_sync2) begin
            rx_data <= rx_shift;
            rx_rdy  <= 1'b1;
          end
        end else begin
          rx_shift <= {rx_sync2, rx_shift[7:1]};
          rx_bits  <= rx_bits + 4'd1;
        end
      end else begin
        rx_baud <= rx_baud + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_remote_cmd_sender.sv
// Randomized bench for remote_cmd_sender: a bit-level TX monitor and RX driver stand in for
// the responder, and a queue/arithmetic model predicts bytes, responses and timeout timing.
module tb_remote_cmd_sender;

  localparam int          BAUD = 16;
  localparam int          TO   = 1000;
  localparam logic [23:0] TO24 = 24'd1000;

  localparam int M_RESP  = 0;
  localparam int M_EARLY = 1;
  localparam int M_TMO   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        snd_cmd = 1'b0;
  logic [15:0] cmd = 16'h0000;
  logic        clr_resp_rdy = 1'b0;
  logic        rx = 1'b1;
  logic        tx, busy, cmd_snt, resp_rdy, timeout;
  logic [7:0]  resp;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_resp = 8'h00;
  int tmo_seen = 0;
  int tmo_exp = 0;
  int bytes_seen = 0;
  int rst_count = 0;

  remote_cmd_sender #(.TIMEOUT_CYC(TO24), .BAUD_DIV(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .snd_cmd(snd_cmd), .cmd(cmd),
    .clr_resp_rdy(clr_resp_rdy), .RX(rx), .TX(tx), .busy(busy),
    .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp),
    .timeout(timeout), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (timeout) tmo_seen++;
  always @(negedge rst_n) rst_count++;

  // Decode every frame on TX and compare against the expected byte queue.
  initial begin
    logic [7:0] b;
    logic       ok;
    int         rc;
    forever begin
      @(negedge tx);
      rc = rst_count;
      repeat (BAUD / 2) @(negedge clk);
      ok = (tx == 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (BAUD) @(negedge clk);
        b[i] = tx;
      end
      repeat (BAUD) @(negedge clk);
      ok = ok & tx;
      if (rc == rst_count) begin
        check_val("tx_framing", ok, 1);
        check_val("tx_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check_val("tx_byte", b, exp_q.pop_front());
        bytes_seen++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      step(BAUD);
    end
  endtask

  // Accept a command from IDLE and check the 2-clock start-bit latency.
  task automatic start_cmd(input logic [15:0] c);
    cmd = c;
    snd_cmd = 1'b1;
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[7:0]);
    step(1);
    snd_cmd = 1'b0;
    cmd = ~c;
    check_val("accept_busy", busy, 1);
    check_val("accept_clr_resp_rdy", resp_rdy, 0);
    check_val("accept_clr_cmd_snt", cmd_snt, 0);
    check_val("start_not_yet", tx, 1);
    step(1);
    check_val("start_bit_latency", tx, 0);
  endtask

  task automatic run_cmd(input logic [15:0] c, input logic [7:0] r, input int mode);
    int n;
    start_cmd(c);
    if (mode == M_EARLY) send_rx(r);
    step($urandom_range(20, 60));
    cmd = c ^ 16'hFFFF;
    snd_cmd = 1'b1;
    step(1);
    snd_cmd = 1'b0;
    n = 0;
    while (!cmd_snt && n < 2000) begin
      step(1);
      n++;
    end
    check_val("cmd_snt_set", cmd_snt, 1);
    if (mode == M_TMO) begin
      n = 0;
      do begin
        step(1);
        n++;
      end while (!timeout && n < 3000);
      tmo_exp++;
      check_val("timeout_delay", n, TO);
      step(1);
      check_val("timeout_one_cycle", timeout, 0);
      check_val("timeout_idle", busy, 0);
      check_val("timeout_resp_rdy", resp_rdy, 0);
      check_val("timeout_resp_kept", resp, exp_resp);
    end else begin
      if (mode == M_RESP) begin
        step($urandom_range(0, 400));
        send_rx(r);
      end
      exp_resp = r;
      n = 0;
      while (!resp_rdy && n < 2000) begin
        step(1);
        n++;
      end
      check_val("resp_rdy_set", resp_rdy, 1);
      check_val("resp_value", resp, exp_resp);
      check_val("resp_idle", busy, 0);
      check_val("no_timeout", tmo_seen, tmo_exp);
      if ($urandom_range(0, 1) == 1) begin
        clr_resp_rdy = 1'b1;
        step(1);
        clr_resp_rdy = 1'b0;
        check_val("clr_resp_rdy", resp_rdy, 0);
      end
    end
    step($urandom_range(5, 30));
  endtask

  initial begin
    int n;
    int b0;
    step(3);
    check_val("reset_tx", tx, 1);
    check_val("reset_busy", busy, 0);
    check_val("reset_cmd_snt", cmd_snt, 0);
    check_val("reset_resp_rdy", resp_rdy, 0);
    check_val("reset_resp", resp, 8'h00);
    check_val("reset_timeout", timeout, 0);
    rst_n = 1'b1;
    step(5);

    run_cmd(16'hA55A, 8'hA5, M_RESP);
    run_cmd(16'hBEEF, 8'h3C, M_RESP);
    run_cmd(16'h1234, 8'h00, M_TMO);
    run_cmd(16'h6E91, 8'h7D, M_EARLY);

    // Stray byte while idle is discarded by the sender.
    send_rx(8'h33);
    step(10);
    check_val("stray_resp_kept", resp, exp_resp);
    check_val("stray_idle", busy, 0);
    run_cmd(16'hC3C3, 8'hCC, M_RESP);

    // Reset while the low byte is on the wire.
    b0 = bytes_seen;
    start_cmd(16'h55AA);
    n = 0;
    while (bytes_seen == b0 && n < 1000) begin
      step(1);
      n++;
    end
    check_val("hi_byte_seen", bytes_seen, b0 + 1);
    step(2 * BAUD);
    rst_n = 1'b0;
    #1;
    check_val("midrst_tx", tx, 1);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_cmd_snt", cmd_snt, 0);
    check_val("midrst_resp", resp, 8'h00);
    void'(exp_q.pop_back());
    exp_resp = 8'h00;
    step(4);
    rst_n = 1'b1;
    step(12 * BAUD);
    run_cmd(16'h0F0F, 8'h96, M_RESP);

    for (int i = 0; i < 8; i++)
      run_cmd(16'($urandom), 8'($urandom), $urandom_range(0, 2));

    step(2 * BAUD);
    check_val("tx_q_drained", exp_q.size(), 0);
    check_val("timeout_total", tmo_seen, tmo_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
